hdc_assoc_search: RTL and testbench

Parametrised hyperdimensional-computing associative search for the inference path. A binary (quantized) query hypervector is streamed in `LANES` bits per beat. The block accumulates a Hamming distance against each of `NUM_CLASSES` stored class hypervectors in parallel, then sequentially scans for the closest class. It generalises the fixed two-class, one-bit datapath to arbitrary dimension, class count and lane width, and adds a ready/valid input, a loadable class memory and tie reporting.

---
 rtl/hdc_pkg.sv | 19 +
 rtl/hdc_popcount.sv | 19 +
 rtl/hdc_assoc_search.sv | 158 +++++++++++++++
 tb/tb_hdc_assoc_search.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared types and sizing helpers for the hyperdimensional associative search.
// Holds the search state encoding, the default dimension and the counter-width helper.
package hdc_pkg;

   localparam int HDC_DIM_DEFAULT = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      RESULT  = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Wide enough to hold a distance of 0..dim inclusive.
   function automatic int cnt_width(input int dim);
      return $clog2(dim + 1);
   endfunction

endpackage

// File: rtl/hdc_popcount.sv
// Combinational popcount of a XOR b across one beat of lanes.
// Zero latency and no flow control; it is evaluated in the same cycle as the beat is accepted.
module hdc_popcount #(
   parameter  int LANES = 1,
   localparam int PC_W  = $clog2(LANES + 1)
) (
   input  logic [LANES-1:0] a,
   input  logic [LANES-1:0] b,
   output logic [PC_W-1:0]  cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         cnt = cnt + PC_W'(a[i] ^ b[i]);
      end
   end

endmodule

// File: rtl/hdc_assoc_search.sv
// Streams a query hypervector, accumulates Hamming distance to every stored class, then scans for the nearest.
// Latency start..done is 1+BEATS+NUM_CLASSES+1 cycles unstalled; in_valid low stalls COMPARE, in_ready is high only in COMPARE.
module hdc_assoc_search
   import hdc_pkg::*;
#(
   parameter  int DIM         = HDC_DIM_DEFAULT,
   parameter  int NUM_CLASSES = 4,
   parameter  int LANES       = 1,
   localparam int BEATS       = DIM / LANES,
   localparam int CNT_W       = cnt_width(DIM),
   localparam int CLS_W       = $clog2(NUM_CLASSES),
   localparam int ADDR_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [LANES-1:0]  in_data,
   output logic              in_ready,
   input  logic              cls_we,
   input  logic [CLS_W-1:0]  cls_sel,
   input  logic [ADDR_W-1:0] cls_addr,
   input  logic [LANES-1:0]  cls_wdata,
   output logic              busy,
   output logic              done,
   output logic [CLS_W-1:0]  result_class,
   output logic [CNT_W-1:0]  result_dist,
   output logic              result_tie
);

   localparam int PC_W = $clog2(LANES + 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] beat_q, beat_d;
   logic [CLS_W-1:0]  scan_q, scan_d;
   logic [CNT_W-1:0]  count_q [NUM_CLASSES];
   logic [CNT_W-1:0]  count_d [NUM_CLASSES];
   logic [CNT_W-1:0]  best_dist_q, best_dist_d;
   logic [CLS_W-1:0]  best_class_q, best_class_d;
   logic              best_tie_q, best_tie_d;
   logic [CNT_W-1:0]  res_dist_q, res_dist_d;
   logic [CLS_W-1:0]  res_class_q, res_class_d;
   logic              res_tie_q, res_tie_d;
   logic [CNT_W-1:0]  cand_dist;
   logic [PC_W-1:0]   pc [NUM_CLASSES];

   logic [LANES-1:0]  mem_q [NUM_CLASSES][BEATS];

   for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pc
      hdc_popcount #(.LANES(LANES)) u_pc (
         .a   (in_data),
         .b   (mem_q[c][beat_q]),
         .cnt (pc[c])
      );
   end

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      scan_d       = scan_q;
      count_d      = count_q;
      best_dist_d  = best_dist_q;
      best_class_d = best_class_q;
      best_tie_d   = best_tie_q;
      res_dist_d   = res_dist_q;
      res_class_d  = res_class_q;
      res_tie_d    = res_tie_q;
      cand_dist    = count_q[scan_q];

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COMPARE;
               beat_d  = '0;
               scan_d  = '0;
               for (int c = 0; c < NUM_CLASSES; c++) begin
                  count_d[c] = '0;
               end
            end
         end
         COMPARE: begin
            if (in_valid) begin
               for (int c = 0; c < NUM_CLASSES; c++) begin
                  count_d[c] = count_q[c] + CNT_W'(pc[c]);
               end
               beat_d = beat_q + 1'b1;
               if (beat_q == ADDR_W'(BEATS - 1)) begin
                  beat_d  = '0;
                  state_d = RESULT;
               end
            end
         end
         RESULT: begin
            // Class 0 seeds the running best; later classes only win when strictly closer.
            if (scan_q == '0 || cand_dist < best_dist_q) begin
               best_dist_d  = cand_dist;
               best_class_d = scan_q;
               best_tie_d   = 1'b0;
            end else if (cand_dist == best_dist_q) begin
               best_tie_d = 1'b1;
            end
            if (scan_q == CLS_W'(NUM_CLASSES - 1)) begin
               state_d     = DONE;
               res_dist_d  = best_dist_d;
               res_class_d = best_class_d;
               res_tie_d   = best_tie_d;
            end else begin
               scan_d = scan_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         scan_q       <= '0;
         best_dist_q  <= '0;
         best_class_q <= '0;
         best_tie_q   <= 1'b0;
         res_dist_q   <= '0;
         res_class_q  <= '0;
         res_tie_q    <= 1'b0;
         for (int c = 0; c < NUM_CLASSES; c++) begin
            count_q[c] <= '0;
         end
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         scan_q       <= scan_d;
         best_dist_q  <= best_dist_d;
         best_class_q <= best_class_d;
         best_tie_q   <= best_tie_d;
         res_dist_q   <= res_dist_d;
         res_class_q  <= res_class_d;
         res_tie_q    <= res_tie_d;
         count_q      <= count_d;
      end
   end

   // Class memory keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (!reset && state_q == IDLE && cls_we) begin
         mem_q[cls_sel][cls_addr] <= cls_wdata;
      end
   end

   assign in_ready     = (state_q == COMPARE);
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign result_class = res_class_q;
   assign result_dist  = res_dist_q;
   assign result_tie   = res_tie_q;

endmodule

// File: tb/tb_hdc_assoc_search.sv
// Bench for hdc_assoc_search: bit-level distance model, per-cycle output compare, directed and random searches.
module tb_hdc_assoc_search;

   localparam int DIM    = 128;
   localparam int NC     = 4;
   localparam int LANES  = 8;
   localparam int BEATS  = DIM / LANES;
   localparam int CNT_W  = $clog2(DIM + 1);
   localparam int CLS_W  = $clog2(NC);
   localparam int ADDR_W = $clog2(BEATS);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [LANES-1:0]  in_data = '0;
   logic              in_ready;
   logic              cls_we = 1'b0;
   logic [CLS_W-1:0]  cls_sel = '0;
   logic [ADDR_W-1:0] cls_addr = '0;
   logic [LANES-1:0]  cls_wdata = '0;
   logic              busy;
   logic              done;
   logic [CLS_W-1:0]  result_class;
   logic [CNT_W-1:0]  result_dist;
   logic              result_tie;

   always #5 clk = ~clk;

   hdc_assoc_search #(.DIM(DIM), .NUM_CLASSES(NC), .LANES(LANES)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .cls_we       (cls_we),
      .cls_sel      (cls_sel),
      .cls_addr     (cls_addr),
      .cls_wdata    (cls_wdata),
      .busy         (busy),
      .done         (done),
      .result_class (result_class),
      .result_dist  (result_dist),
      .result_tie   (result_tie)
   );

   int n_cmp = 0;
   int n_bad = 0;

   bit mem_m [NC][DIM];
   bit q_m   [DIM];
   int mdist [NC];
   int m_class;
   int m_dist;
   bit m_tie;

   logic        exp_done = 1'b0;
   logic        exp_busy = 1'b0;
   logic        exp_rdy  = 1'b0;
   logic [31:0] held_class = '0;
   logic [31:0] held_dist  = '0;
   logic [31:0] held_tie   = '0;
   bit          mon_en = 1'b0;
   int          acc_cnt = 0;
   int          busy_cnt = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   // Nearest class by plain bit counting; ties go to the lowest index.
   function automatic void run_model();
      int best;
      int nbest;
      int d;
      best  = DIM + 1;
      nbest = 0;
      for (int c = 0; c < NC; c++) begin
         d = 0;
         for (int i = 0; i < DIM; i++) d += int'(mem_m[c][i] ^ q_m[i]);
         mdist[c] = d;
         if (d < best) best = d;
      end
      m_dist  = best;
      m_class = -1;
      for (int c = 0; c < NC; c++) begin
         if (mdist[c] == best) begin
            if (m_class < 0) m_class = c;
            nbest++;
         end
      end
      m_tie = (nbest > 1);
   endfunction

   function automatic void pin(input string nm, input int c, input int d, input bit t);
      chk({nm, "_model_class"}, m_class, c);
      chk({nm, "_model_dist"}, m_dist, d);
      chk({nm, "_model_tie"}, 32'(m_tie), 32'(t));
   endfunction

   function automatic void set_q(input int kind);
      for (int i = 0; i < DIM; i++) begin
         case (kind)
            0:       q_m[i] = 1'b0;
            1:       q_m[i] = 1'b1;
            2:       q_m[i] = i[0];
            default: q_m[i] = 1'($urandom_range(1));
         endcase
      end
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         chk("done", done, exp_done);
         chk("busy", busy, exp_busy);
         chk("in_ready", in_ready, exp_rdy);
         chk("result_class", result_class, held_class);
         chk("result_dist", result_dist, held_dist);
         chk("result_tie", result_tie, held_tie);
         if (in_valid && in_ready) acc_cnt++;
         if (busy) busy_cnt++;
      end
   end

   task automatic load_class(input int c);
      for (int b = 0; b < BEATS; b++) begin
         cls_we   = 1'b1;
         cls_sel  = CLS_W'(c);
         cls_addr = ADDR_W'(b);
         for (int i = 0; i < LANES; i++) cls_wdata[i] = mem_m[c][b*LANES+i];
         @(posedge clk); #1;
      end
      cls_we = 1'b0;
   endtask

   task automatic do_search(input int bubble_pct, input bit inject, input int abort_at, input bit chk_len);
      int b;
      int guard;
      b     = 0;
      guard = 0;
      run_model();
      acc_cnt  = 0;
      busy_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      exp_busy = 1'b1;
      exp_rdy  = 1'b1;
      while (b < BEATS) begin
         in_valid = ($urandom_range(99) >= bubble_pct);
         for (int i = 0; i < LANES; i++) in_data[i] = in_valid ? q_m[b*LANES+i] : 1'($urandom_range(1));
         if (inject) begin
            cls_we    = 1'($urandom_range(1));
            start     = 1'($urandom_range(1));
            cls_sel   = '0;
            cls_addr  = '0;
            cls_wdata = '1;
         end
         @(posedge clk); #1;
         if (in_valid) b++;
         guard++;
         if (guard > 2000) begin
            chk("beat_budget", 32'(b), 32'(BEATS));
            break;
         end
         if (abort_at > 0 && b == abort_at) begin
            reset    = 1'b1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            reset      = 1'b0;
            exp_busy   = 1'b0;
            exp_rdy    = 1'b0;
            held_class = '0;
            held_dist  = '0;
            held_tie   = '0;
            chk("beats_before_reset", acc_cnt, abort_at);
            @(posedge clk); #1;
            return;
         end
      end
      in_valid = 1'b0;
      cls_we   = 1'b0;
      start    = 1'b0;
      exp_rdy  = 1'b0;
      repeat (NC) @(posedge clk);
      #1;
      exp_done   = 1'b1;
      held_class = 32'(m_class);
      held_dist  = 32'(m_dist);
      held_tie   = 32'(m_tie);
      @(posedge clk); #1;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      chk("beats_accepted", acc_cnt, BEATS);
      if (chk_len) chk("search_len", busy_cnt + 1, 1 + BEATS + NC + 1);
   endtask

   initial begin
      int nflip;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < DIM; i++) begin
         mem_m[0][i] = 1'b0;
         mem_m[1][i] = 1'b1;
         mem_m[2][i] = i[0];
         mem_m[3][i] = (i < 64);
      end
      for (int c = 0; c < NC; c++) load_class(c);

      set_q(0); run_model();
      pin("zero", 0, 0, 1'b0);
      chk("zero_model_d1", mdist[1], 128);
      chk("zero_model_d3", mdist[3], 64);
      do_search(0, 1'b0, 0, 1'b1);

      set_q(1); run_model();
      pin("ones", 1, 0, 1'b0);
      do_search(0, 1'b0, 0, 1'b0);

      set_q(0);
      do_search(0, 1'b0, 10, 1'b0);
      do_search(0, 1'b0, 0, 1'b0);

      set_q(2); run_model();
      pin("alt", 2, 0, 1'b0);
      do_search(0, 1'b0, 0, 1'b1);

      set_q(0);
      do_search(30, 1'b0, 0, 1'b0);

      do_search(20, 1'b1, 0, 1'b0);
      do_search(0, 1'b0, 0, 1'b0);

      set_q(3);
      for (int i = 0; i < DIM; i++) begin
         mem_m[0][i] = q_m[i];
         mem_m[2][i] = q_m[i];
      end
      load_class(0);
      load_class(2);
      run_model();
      pin("tie", 0, 0, 1'b1);
      do_search(0, 1'b0, 0, 1'b0);

      repeat (12) begin
         for (int c = 0; c < NC; c++)
            for (int i = 0; i < DIM; i++) mem_m[c][i] = 1'($urandom_range(1));
         for (int c = 0; c < NC; c++) load_class(c);
         begin
            int src;
            src   = $urandom_range(NC - 1);
            nflip = $urandom_range(6);
            for (int i = 0; i < DIM; i++) q_m[i] = mem_m[src][i];
            for (int f = 0; f < nflip; f++) begin
               int p;
               p = $urandom_range(DIM - 1);
               q_m[p] = ~q_m[p];
            end
         end
         do_search(30, 1'b0, 0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
